// File: rtl/nested_isqrt_pipe.sv
// Fully pipelined nested integer square root: res = isqrt(arg[N-1] + ... isqrt(arg[1] + isqrt(arg[0]))).
// Define NESTED_ISQRT_SAT_EN to make every level adder saturate instead of wrapping.

module isqrt #(
  parameter int n_pipe_stages = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int S   = (n_pipe_stages < 1) ? 1 : n_pipe_stages;
  localparam int IPS = (16 + S - 1) / S;

  typedef struct packed {
    logic [31:0] x;
    logic [17:0] rem;
    logic [15:0] root;
  } sq_t;

  // Digit-by-digit root: each iteration pulls the next two radicand bits into the remainder.
  function automatic sq_t sqrt_steps(input sq_t in_st, input int first);
    sq_t r;
    r = in_st;
    for (int j = 0; j < IPS; j++) begin
      if (first + j < 16) begin
        r.rem = {r.rem[15:0], r.x[31:30]};
        r.x   = {r.x[29:0], 2'b00};
        if (r.rem >= {r.root, 2'b01}) begin
          r.rem  = r.rem - {r.root, 2'b01};
          r.root = {r.root[14:0], 1'b1};
        end else begin
          r.root = {r.root[14:0], 1'b0};
        end
      end
    end
    return r;
  endfunction

  logic [S:0] st_vld;
  sq_t        st [S];

  assign st_vld[0] = x_vld;
  assign st[0]     = {x, 18'd0, 16'd0};

  for (genvar s = 0; s < S; s++) begin : g_stage
    logic vld_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= st_vld[s];
    end
    assign st_vld[s+1] = vld_q;

    if (s < S - 1) begin : g_mid
      sq_t st_q, st_d;

      // NOTE: the hold branch is explicit, so this is a plain mux and never a latch.
      always_comb st_d = st_vld[s] ? sqrt_steps(st[s], s * IPS) : st_q;

      // NOTE: datapath registers carry no reset; the valid bits alone say whether they mean anything.
      always_ff @(posedge clk) st_q <= st_d;

      assign st[s+1] = st_q;
    end else begin : g_last
      logic [15:0] root_q, root_d;

      always_comb root_d = st_vld[s] ? 16'(sqrt_steps(st[s], s * IPS)) : root_q;

      always_ff @(posedge clk) begin
        if (rst) root_q <= '0;
        else     root_q <= root_d;
      end

      assign y = root_q;
    end
  end

  assign y_vld = st_vld[S];

endmodule

module nested_isqrt_pipe #(
  parameter int N_LEVELS     = 3,
  parameter int WIDTH        = 32,
  parameter int ISQRT_STAGES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  input  logic [N_LEVELS*WIDTH-1:0] args,
  output logic                      res_vld,
  output logic [WIDTH-1:0]          res,
  output logic                      busy
);

  localparam int L  = N_LEVELS * ISQRT_STAGES + (N_LEVELS - 1);
  localparam int CW = $clog2(L + 1);

  logic [N_LEVELS-1:0][15:0] lvl_y;
  logic [N_LEVELS-1:0]       lvl_vld;

  isqrt #(.n_pipe_stages(ISQRT_STAGES)) u_isqrt_0 (
    .clk   (clk),
    .rst   (rst),
    .x_vld (arg_vld),
    .x     (32'(args[WIDTH-1:0])),
    .y_vld (lvl_vld[0]),
    .y     (lvl_y[0])
  );

  for (genvar k = 1; k < N_LEVELS; k++) begin : g_level
    // Counting the raw input as tap 0, arg[k] reaches the adder exactly when y(k-1) does.
    localparam int D = k * (ISQRT_STAGES + 1) - 1;

    logic [WIDTH-1:0] dl_q [D];
    logic [WIDTH-1:0] dl_d [D];
    logic [D-1:0]     dlv_q, dlv_d;

    always_comb begin
      dlv_d[0] = arg_vld;
      dl_d[0]  = arg_vld ? args[k*WIDTH +: WIDTH] : dl_q[0];
      for (int i = 1; i < D; i++) begin
        dlv_d[i] = dlv_q[i-1];
        dl_d[i]  = dlv_q[i-1] ? dl_q[i-1] : dl_q[i];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) dlv_q <= '0;
      else     dlv_q <= dlv_d;
    end

    always_ff @(posedge clk) dl_q <= dl_d;

    logic [31:0]      y_prev;
    logic [WIDTH-1:0] sum_w, sum_q, sum_d;
    logic             sum_vld_q, ld;

    assign y_prev = 32'(lvl_y[k-1]);
    assign ld     = lvl_vld[k-1] & dlv_q[D-1];

`ifdef NESTED_ISQRT_SAT_EN
    logic [WIDTH:0] sum_full;
    always_comb begin
      sum_full = {1'b0, dl_q[D-1]} + {1'b0, y_prev[WIDTH-1:0]};
      sum_w    = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
    end
`else
    always_comb sum_w = dl_q[D-1] + y_prev[WIDTH-1:0];
`endif

    always_comb sum_d = ld ? sum_w : sum_q;

    always_ff @(posedge clk) begin
      if (rst) sum_vld_q <= 1'b0;
      else     sum_vld_q <= ld;
    end

    always_ff @(posedge clk) sum_q <= sum_d;

    isqrt #(.n_pipe_stages(ISQRT_STAGES)) u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .x_vld (sum_vld_q),
      .x     (32'(sum_q)),
      .y_vld (lvl_vld[k]),
      .y     (lvl_y[k])
    );
  end

  logic [31:0] y_last;
  assign y_last  = 32'(lvl_y[N_LEVELS-1]);
  assign res     = y_last[WIDTH-1:0];
  assign res_vld = lvl_vld[N_LEVELS-1];

  // Sets in flight: issue and retire in the same cycle cancel out.
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (arg_vld && !res_vld)      cnt_d = cnt_q + CW'(1);
    else if (!arg_vld && res_vld) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_nested_isqrt_pipe.sv
// Directed bench for nested_isqrt_pipe: default 3-level/32-bit instance plus a 2-level/8-bit instance.
// Results are scoreboarded by value and arrival cycle.

module tb_nested_isqrt_pipe;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int S  = 8;
  localparam int L  = N * S + (N - 1);
  localparam int L8 = 2 * S + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           arg_vld;
  logic [N*W-1:0] args;
  logic           res_vld;
  logic [W-1:0]   res;
  logic           busy;

  logic           arg_vld8;
  logic [15:0]    args8;
  logic           res_vld8;
  logic [7:0]     res8;
  logic           busy8;

  nested_isqrt_pipe #(.N_LEVELS(N), .WIDTH(W), .ISQRT_STAGES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (arg_vld),
    .args    (args),
    .res_vld (res_vld),
    .res     (res),
    .busy    (busy)
  );

  nested_isqrt_pipe #(.N_LEVELS(2), .WIDTH(8), .ISQRT_STAGES(S)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (arg_vld8),
    .args    (args8),
    .res_vld (res_vld8),
    .res     (res8),
    .busy    (busy8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
    logic [31:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = {32'd0, r | (32'd1 << b)};
      if (t * t <= {32'd0, x}) r = t[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef NESTED_ISQRT_SAT_EN
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  function automatic logic [31:0] ref_nested(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return ref_isqrt(ref_add(a, ref_isqrt(ref_add(b, ref_isqrt(c)))));
  endfunction

  logic [31:0] exp_q [$];
  int          due_q [$];
  logic [31:0] last_exp;
  bit          sb_en;

  // Every result must arrive in order, on its due cycle, and res must hold between results.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    int          d;
    if (sb_en) begin
      if (res_vld) begin
        if (exp_q.size() == 0) begin
          check("spurious_res_vld", 1, 0);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("res_data", res, e);
          check("res_latency", cyc, d);
          last_exp = e;
        end
      end else begin
        check("res_hold", res, last_exp);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          check("res_missing", 0, 1);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] exp);
    @(posedge clk);
    #1;
    arg_vld = v;
    args    = {a, b, c};
    if (v) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + L);
    end
  endtask

  task automatic drive_rand();
    logic [31:0] a, b, c;
    a = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(5000, 0);
    b = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(5000, 0);
    c = $urandom;
    drive(1'b1, a, b, c, ref_nested(a, b, c));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2 * L) begin
      drive(1'b0, 0, 0, 0, 0);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) drive(1'b0, 0, 0, 0, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int          t;
    bit          found;
    logic [31:0] a, b, c;
    logic [7:0]  exp8;

    rst      = 1'b1;
    arg_vld  = 1'b0;
    args     = '0;
    arg_vld8 = 1'b0;
    args8    = '0;
    sb_en    = 1'b0;
    last_exp = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_vld", res_vld, 0);
    check("rst_res", res, 0);
    check("rst_busy", busy, 0);
    check("rst_res_vld8", res_vld8, 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    sb_en = 1'b1;

    // Single set: 16 -> 4, 4+4=8 -> 2, 1+2=3 -> 1.
    drive(1'b1, 1, 4, 16, 1);
    for (int i = 1; i <= L + 2; i++) begin
      drive(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_busy", busy, i <= L);
      check("t1_res_vld", res_vld, i == L);
    end

    // 49->7, 16->4, 104->10; all zero -> 0; 2^32-1 -> 65535 -> 255 -> 15.
    drive(1'b1, 100, 9, 49, 10);
    drive(1'b1, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 32'hFFFF_FFFF, 15);
    drain();

    // Random traffic with roughly half the cycles idle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1) drive_rand();
      else                           drive(1'b0, 0, 0, 0, 0);
    end
    drain();

    // Two levels at 8 bits: 255 -> 15, then 250+15 overflows 8 bits.
`ifdef NESTED_ISQRT_SAT_EN
    exp8 = 8'd15;
`else
    exp8 = 8'd3;
`endif
    @(posedge clk);
    #1;
    arg_vld8 = 1'b1;
    args8    = {8'd250, 8'd255};
    t        = cyc;
    @(posedge clk);
    #1;
    arg_vld8 = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (res_vld8) begin
        found = 1'b1;
        check("t4_res8", res8, exp8);
        check("t4_latency8", cyc - t, L8);
      end
    end
    if (!found) check("t4_res_vld8_timeout", 0, 1);

    // Reset in the middle of a stream: nothing issued before it may come out.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      rst = (i == 12);
      if (i == 13) begin
        exp_q.delete();
        due_q.delete();
        last_exp = '0;
      end
      arg_vld = (i < 10) || (i == 14);
      a = $urandom_range(70000, 0);
      b = $urandom_range(70000, 0);
      c = $urandom;
      args = {a, b, c};
      if (arg_vld) begin
        exp_q.push_back(ref_nested(a, b, c));
        due_q.push_back(cyc + L);
      end
      if (i == 13) begin
        @(negedge clk);
        check("t5_busy_after_rst", busy, 0);
      end
    end
    drain();

    // Continuous issue: the in-flight count must settle at L and never pass it.
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      @(negedge clk);
      if (i > 0) check("t6_busy_streaming", busy, 1);
      check("t6_cnt_le_L", dut.cnt_q <= L, 1);
    end
    check("t6_cnt_saturated", dut.cnt_q, L);
    for (int j = 1; j <= L + 1; j++) begin
      drive(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      check("t6_busy_tail", busy, j <= L);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
